// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS main control decoder: opcodes, ALUOp codes
// and the packed control bundle.
package mips_ctrl_pkg;

  localparam int OPC_W   = 6;
  localparam int ALUOP_W = 2;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  // Field order matches the decode table, MSB first.
  typedef struct packed {
    logic               reg_write;
    logic               reg_dst;
    logic               alu_src;
    logic               branch;
    logic               mem_write;
    logic               mem_to_reg;
    logic               jump;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mips_main_decoder.sv
// Purely combinational opcode decode into the control bundle plus an
// illegal-opcode flag.
module mips_main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output ctrl_t            ctrl_o,
  output logic             illegal_o
);

  // Unknown or X/Z opcodes fall to the default arm: everything off, flagged.
  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      OP_J: begin
        ctrl_o.jump = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mips_control_unit.sv
// Main control unit: combinational decode followed by a synchronously cleared
// output register, giving one cycle of latency and no handshake.
module mips_control_unit
  import mips_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   opcode,
  output logic               Jump,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               MemtoReg,
  output logic               MemWrite,
  output logic               Branch,
  output logic               ALUSrc,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               illegal
);

  ctrl_t ctrl_d, ctrl_q;
  logic  illegal_d, illegal_q;

  mips_main_decoder u_dec (
    .opcode_i  (opcode),
    .ctrl_o    (ctrl_d),
    .illegal_o (illegal_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign RegWrite = ctrl_q.reg_write;
  assign RegDst   = ctrl_q.reg_dst;
  assign ALUSrc   = ctrl_q.alu_src;
  assign Branch   = ctrl_q.branch;
  assign MemWrite = ctrl_q.mem_write;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign Jump     = ctrl_q.jump;
  assign ALUOp    = ctrl_q.alu_op;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_mips_control_unit.sv
// Self-checking bench for mips_control_unit: directed scenarios plus random
// opcode streams checked against a table-lookup reference model.
module tb_mips_control_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       Jump, MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite, illegal;
  logic [1:0] ALUOp;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: {illegal, RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump, ALUOp}
  logic [9:0] exp_q[$];

  // Reference decode table, transcribed from the instruction set description.
  logic [5:0] ref_ops  [6] = '{6'b000000, 6'b100011, 6'b101011,
                               6'b000100, 6'b001000, 6'b000010};
  logic [8:0] ref_pats [6] = '{9'b1_1_0_0_0_0_0_10, 9'b1_0_1_0_0_1_0_00,
                               9'b0_0_1_0_1_0_0_00, 9'b0_0_0_1_0_0_0_01,
                               9'b1_0_1_0_0_0_0_00, 9'b0_0_0_0_0_0_1_00};

  mips_control_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .Jump     (Jump),
    .ALUOp    (ALUOp),
    .MemtoReg (MemtoReg),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .ALUSrc   (ALUSrc),
    .RegDst   (RegDst),
    .RegWrite (RegWrite),
    .illegal  (illegal)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst_n  = 1'b0;
    opcode = 6'b000000;
  end

  function automatic logic [9:0] model(input logic [5:0] op);
    for (int i = 0; i < 6; i++)
      if (op == ref_ops[i]) return {1'b0, ref_pats[i]};
    return {1'b1, 9'b0};
  endfunction

  function automatic logic [9:0] observed();
    return {illegal, RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump, ALUOp};
  endfunction

  // Driver tasks: inputs change on the falling edge, outputs sampled 1ns after rising edge.
  task automatic drive(input logic [5:0] op, input logic rn);
    @(negedge clk);
    opcode = op;
    rst_n  = rn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(6'b000000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (observed() !== 10'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %b expected %b", i, observed(), 10'b0);
      end
    end
  endtask

  task automatic test_sequence();
    logic [9:0] exp_v [6] = '{10'b0_1_1_0_0_0_0_0_10, 10'b0_1_0_1_0_0_1_0_00,
                              10'b0_0_0_1_0_1_0_0_00, 10'b0_0_0_0_1_0_0_0_01,
                              10'b0_1_0_1_0_0_0_0_00, 10'b0_0_0_0_0_0_0_1_00};
    logic [5:0] ops   [6] = '{6'b000000, 6'b100011, 6'b101011,
                              6'b000100, 6'b001000, 6'b000010};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], 1'b1);
      tick();
      n_checks++;
      if (observed() !== exp_v[i]) begin
        n_fail++;
        $display("FAIL sequence op=%b: got %b expected %b", ops[i], observed(), exp_v[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [3] = '{6'b111111, 6'b001101, 6'b100011};
    logic [9:0] ev  [3] = '{10'b1_0000000_00, 10'b1_0000000_00, 10'b0_1_0_1_0_0_1_0_00};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 1'b1);
      tick();
      n_checks++;
      if (observed() !== ev[i]) begin
        n_fail++;
        $display("FAIL illegal op=%b: got %b expected %b", ops[i], observed(), ev[i]);
      end
    end
  endtask

  task automatic test_latency();
    drive(6'b100011, 1'b1);
    tick();
    drive(6'b101011, 1'b1);
    #1;
    n_checks++;
    if (observed() !== model(6'b100011)) begin
      n_fail++;
      $display("FAIL latency_hold: got %b expected %b", observed(), model(6'b100011));
    end
    tick();
    n_checks++;
    if (observed() !== model(6'b101011)) begin
      n_fail++;
      $display("FAIL latency_update: got %b expected %b", observed(), model(6'b101011));
    end
  endtask

  task automatic test_reset_mid();
    drive(6'b100011, 1'b1);
    tick();
    n_checks++;
    if (RegWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre RegWrite: got %b expected 1", RegWrite);
    end
    drive(6'b100011, 1'b0);
    tick();
    n_checks++;
    if (observed() !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got %b expected %b", observed(), 10'b0);
    end
    drive(6'b100011, 1'b1);
    tick();
    n_checks++;
    if (observed() !== model(6'b100011)) begin
      n_fail++;
      $display("FAIL reset_mid_release: got %b expected %b", observed(), model(6'b100011));
    end
  endtask

  task automatic test_sweep();
    int n_illegal = 0;
    for (int op = 0; op < 64; op++) begin
      drive(6'(op), 1'b1);
      tick();
      if (illegal === 1'b1) n_illegal++;
      n_checks++;
      if (observed() !== model(6'(op))) begin
        n_fail++;
        $display("FAIL sweep op=%b: got %b expected %b", 6'(op), observed(), model(6'(op)));
      end
      n_checks++;
      if ((RegWrite & MemWrite) !== 1'b0 || (Jump & Branch) !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_invariant op=%b: RW&MW=%b J&B=%b expected 0,0",
                 6'(op), RegWrite & MemWrite, Jump & Branch);
      end
    end
    n_checks++;
    if (n_illegal != 58) begin
      n_fail++;
      $display("FAIL sweep_illegal_count: got %0d expected 58", n_illegal);
    end
  endtask

  // Back-to-back random stream with occasional reset pulses.
  task automatic test_back_to_back();
    logic [5:0] op;
    logic       rn;
    logic [9:0] e;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) op = ref_ops[$urandom_range(0, 5)];
      else                           op = 6'($urandom);
      rn = ($urandom_range(0, 15) != 0);
      drive(op, rn);
      exp_q.push_back(rn ? model(op) : 10'b0);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL random[%0d] op=%b rst_n=%b: got %b expected %b", i, op, rn, observed(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_illegal();
    test_latency();
    test_reset_mid();
    test_sweep();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
